charge_controller: RTL and testbench

CHARGE_CONTROLLER -- requirements
Module: charge_controller

---
 rtl/charger_pkg.sv | 33 +++
 rtl/charge_controller_if.sv | 26 ++
 rtl/key_edge.sv | 29 ++
 rtl/charge_controller.sv | 154 +++++++++++++++
 tb/tb_charge_controller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/charger_pkg.sv
// Shared definitions for the charge controller: state encoding, key priority
// and default parameter values.
package charger_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INPUT  = 2'd1;
    localparam logic [1:0] ST_CHARGE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int DEF_MAX_MONEY     = 20;
    localparam int DEF_TIME_PER_UNIT = 2;
    localparam int DEF_DONE_TICKS    = 3;
    localparam int DEF_TIMEOUT_TICKS = 10;

    // Enumerated in descending priority after KEY_NONE.
    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_CLEAR,
        KEY_CONFIRM,
        KEY_START,
        KEY_DIGIT
    } key_e;

    function automatic key_e key_pick(input logic clr, input logic cfm,
                                      input logic st, input logic dig);
        if (clr)      return KEY_CLEAR;
        else if (cfm) return KEY_CONFIRM;
        else if (st)  return KEY_START;
        else if (dig) return KEY_DIGIT;
        else          return KEY_NONE;
    endfunction

endpackage

// File: rtl/charge_controller_if.sv
// Key-decoder inputs, time base and status outputs of the charge controller.
interface charge_controller_if;

    logic       tick;
    logic       start;
    logic       clear;
    logic       confirm;
    logic       press_num;
    logic [3:0] value;
    logic [1:0] state;
    logic [4:0] money;
    logic [5:0] remain;
    logic       charging;
    logic       done;

    modport master (
        output tick, start, clear, confirm, press_num, value,
        input  state, money, remain, charging, done
    );

    modport slave (
        input  tick, start, clear, confirm, press_num, value,
        output state, money, remain, charging, done
    );

endinterface

// File: rtl/key_edge.sv
// Registered rising-edge detector for one key level; a key already held when
// reset releases is absorbed and never reported as a press.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic rise
);

    logic key_p0;
    logic key_p1;
    logic armed_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0   <= 1'b0;
            key_p1   <= 1'b0;
            armed_p0 <= 1'b0;
        end else begin
            key_p0   <= key;
            // First cycle after reset loads the history with the live level.
            key_p1   <= armed_p0 ? key_p0 : key;
            armed_p0 <= 1'b1;
        end
    end

    assign rise = key_p0 & ~key_p1;

endmodule

// File: rtl/charge_controller.sv
// Coin-operated charge controller: key entry of an amount, timed charge, done hold.
// Define IDLE_TIMEOUT_EN to return from INPUT to IDLE after TIMEOUT_TICKS idle ticks.
module charge_controller
    import charger_pkg::*;
#(
    parameter int MAX_MONEY     = DEF_MAX_MONEY,
    parameter int TIME_PER_UNIT = DEF_TIME_PER_UNIT,
    parameter int DONE_TICKS    = DEF_DONE_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input logic                clk,
    input logic                rst_n,
    charge_controller_if.slave bus
);

    // One width serves both tick counters.
    localparam int CNT_MAX = (DONE_TICKS > TIMEOUT_TICKS) ? DONE_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    function automatic logic [8:0] digit_append(input logic [4:0] m, input logic [3:0] v);
        return 9'(m) * 9'd10 + 9'(v);
    endfunction

    function automatic logic [5:0] sat_dec(input logic [5:0] r);
        return (r == 6'd0) ? 6'd0 : r - 6'd1;
    endfunction

    logic start_e, clear_e, confirm_e, num_e;
    key_e key_sel;

    key_edge u_start   (.clk(clk), .rst_n(rst_n), .key(bus.start),     .rise(start_e));
    key_edge u_clear   (.clk(clk), .rst_n(rst_n), .key(bus.clear),     .rise(clear_e));
    key_edge u_confirm (.clk(clk), .rst_n(rst_n), .key(bus.confirm),   .rise(confirm_e));
    key_edge u_num     (.clk(clk), .rst_n(rst_n), .key(bus.press_num), .rise(num_e));

    assign key_sel = key_pick(clear_e, confirm_e, start_e, num_e);

    logic [1:0]       state_q, state_d;
    logic [4:0]       money_q, money_d;
    logic [5:0]       remain_q, remain_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [3:0]       value_q;
    logic [8:0]       cand;
    logic             charging_q, done_q;
`ifdef IDLE_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign cand = digit_append(money_q, value_q);

    always_comb begin
        state_d    = state_q;
        money_d    = money_q;
        remain_d   = remain_q;
        done_cnt_d = done_cnt_q;
`ifdef IDLE_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    money_d = '0;
                    state_d = ST_INPUT;
                end
            end
            ST_INPUT: begin
                case (key_sel)
                    KEY_CLEAR:   money_d = '0;
                    KEY_CONFIRM: begin
                        if (money_q != 5'd0) begin
                            remain_d = 6'(32'(money_q) * TIME_PER_UNIT);
                            state_d  = ST_CHARGE;
                        end
                    end
                    KEY_DIGIT: begin
                        if (cand <= 9'(MAX_MONEY)) money_d = 5'(cand);
                    end
                    default: ;
                endcase
`ifdef IDLE_TIMEOUT_EN
                // Any key edge restarts the idle count; only quiet ticks advance it.
                if (key_sel == KEY_NONE) begin
                    to_cnt_d = to_cnt_q;
                    if (bus.tick) begin
                        if (to_cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            state_d  = ST_IDLE;
                            money_d  = '0;
                            to_cnt_d = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + CNT_W'(1);
                        end
                    end
                end
`endif
            end
            ST_CHARGE: begin
                if (bus.tick) begin
                    remain_d = sat_dec(remain_q);
                    if (remain_q == 6'd1) begin
                        state_d    = ST_DONE;
                        done_cnt_d = CNT_W'(DONE_TICKS);
                    end
                end
            end
            default: begin
                if (start_e) begin
                    state_d = ST_INPUT;
                    money_d = '0;
                end else if (bus.tick) begin
                    if (done_cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        money_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q - CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            money_q    <= '0;
            remain_q   <= '0;
            done_cnt_q <= '0;
            value_q    <= '0;
            charging_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef IDLE_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            money_q    <= money_d;
            remain_q   <= remain_d;
            done_cnt_q <= done_cnt_d;
            // Captured on the same edge that registers the press_num level.
            if (bus.press_num) value_q <= bus.value;
            charging_q <= (state_d == ST_CHARGE);
            done_q     <= (state_d == ST_DONE);
`ifdef IDLE_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign bus.state    = state_q;
    assign bus.money    = money_q;
    assign bus.remain   = remain_q;
    assign bus.charging = charging_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_charge_controller.sv
// Bench for charge_controller: directed scenarios then random key/tick events
// checked against an event-level model of the charger rules.
module tb_charge_controller;

    localparam int MAXM  = 20;
    localparam int TPU   = 2;
    localparam int DONET = 3;
    localparam int TOT   = 10;

    localparam logic [3:0] K_CLR = 4'b1000;
    localparam logic [3:0] K_CFM = 4'b0100;
    localparam logic [3:0] K_ST  = 4'b0010;
    localparam logic [3:0] K_NUM = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    charge_controller_if bus ();

    charge_controller #(
        .MAX_MONEY(MAXM), .TIME_PER_UNIT(TPU), .DONE_TICKS(DONET), .TIMEOUT_TICKS(TOT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Model: 0 idle, 1 entering amount, 2 charging, 3 finished.
    int m_state, m_money, m_remain, m_dleft, m_idle;

    task automatic model_reset();
        m_state = 0; m_money = 0; m_remain = 0; m_dleft = 0; m_idle = 0;
    endtask

    task automatic model_key(input logic [3:0] k, input int v);
        case (m_state)
            0: if (k[1]) begin m_money = 0; m_state = 1; m_idle = 0; end
            1: begin
                m_idle = 0;
                if (k[3]) m_money = 0;
                else if (k[2]) begin
                    if (m_money != 0) begin m_remain = m_money * TPU; m_state = 2; end
                end
                else if (k[1]) ;
                else if (k[0] && (m_money * 10 + v <= MAXM)) m_money = m_money * 10 + v;
            end
            3: if (k[1]) begin m_state = 1; m_money = 0; m_idle = 0; end
            default: ;
        endcase
    endtask

    task automatic model_tick();
        case (m_state)
            1: begin
`ifdef IDLE_TIMEOUT_EN
                m_idle++;
                if (m_idle == TOT) begin m_state = 0; m_money = 0; m_idle = 0; end
`endif
            end
            2: begin
                if (m_remain > 0) m_remain--;
                if (m_remain == 0) begin m_state = 3; m_dleft = DONET; end
            end
            3: begin
                m_dleft--;
                if (m_dleft == 0) begin m_state = 0; m_money = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        chk($sformatf("%s.state", tag),    8'(bus.state),    8'(m_state));
        chk($sformatf("%s.money", tag),    8'(bus.money),    8'(m_money));
        chk($sformatf("%s.remain", tag),   8'(bus.remain),   8'(m_remain));
        chk($sformatf("%s.charging", tag), 8'(bus.charging), 8'(m_state == 2));
        chk($sformatf("%s.done", tag),     8'(bus.done),     8'(m_state == 3));
    endtask

    // Raise keys, hold them, release; optional tick lands on the acting edge.
    task automatic press(input logic [3:0] k, input int v, input int hold, input bit tk);
        @(negedge clk);
        bus.clear = k[3]; bus.confirm = k[2]; bus.start = k[1]; bus.press_num = k[0];
        bus.value = 4'(v);
        for (int i = 1; i <= hold + 2; i++) begin
            @(negedge clk);
            bus.tick = (i == 1) && tk;
            if (i == hold) begin
                bus.clear = 1'b0; bus.confirm = 1'b0; bus.start = 1'b0; bus.press_num = 1'b0;
                bus.value = 4'($urandom);
            end
        end
        model_key(k, v);
        if (tk) model_tick();
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        model_tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0] k;
        n_chk = 0; n_pass = 0;
        bus.tick = 0; bus.start = 0; bus.clear = 0; bus.confirm = 0;
        bus.press_num = 0; bus.value = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_model("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full charge cycle: 15 units -> 30 ticks -> done hold -> idle.
        press(K_ST, 0, 1, 0);  check_model("s37_start");
        press(K_NUM, 1, 2, 0); check_model("s37_d1");
        press(K_NUM, 5, 1, 0); chk("s37_money", 8'(bus.money), 8'd15);
        press(K_CFM, 0, 1, 0);
        chk("s37_remain", 8'(bus.remain), 8'd30);
        chk("s37_state", 8'(bus.state), 8'd2);
        repeat (29) do_tick();
        check_model("s37_t29");
        chk("s37_rem1", 8'(bus.remain), 8'd1);
        do_tick();
        chk("s37_done_state", 8'(bus.state), 8'd3);
        chk("s37_done_flag", 8'(bus.done), 8'd1);
        repeat (2) do_tick();
        check_model("s37_hold");
        do_tick();
        chk("s37_idle", 8'(bus.state), 8'd0);
        check_model("s37_end");

        // Digit overflow rejection and clear.
        press(K_ST, 0, 1, 0);
        press(K_NUM, 2, 1, 0);
        press(K_NUM, 5, 1, 0);
        press(K_NUM, 3, 1, 0);
        chk("s38_money", 8'(bus.money), 8'd2);
        press(K_CLR, 0, 1, 0);
        chk("s38_clr_money", 8'(bus.money), 8'd0);
        chk("s38_clr_state", 8'(bus.state), 8'd1);

        // Zero confirm ignored; simultaneous keys obey priority.
        press(K_CFM, 0, 1, 0);
        chk("s39_cfm0", 8'(bus.state), 8'd1);
        press(K_NUM, 7, 1, 0);
        press(K_CLR | K_CFM | K_ST, 0, 1, 0);
        chk("s39_prio_money", 8'(bus.money), 8'd0);
        chk("s39_prio_state", 8'(bus.state), 8'd1);
        press(K_NUM, 1, 1, 0);
        press(K_CFM | K_NUM, 2, 1, 0);
        chk("s39_cfm_over_dig", 8'(bus.remain), 8'd2);
        check_model("s39_charge");
        press(K_CFM, 0, 1, 1);
        check_model("s28_key_tick");
        do_tick();
        check_model("s26_done");
        press(K_ST, 0, 1, 0);
        check_model("s26_restart");

`ifdef IDLE_TIMEOUT_EN
        repeat (9) do_tick();
        chk("s41_t9", 8'(bus.state), 8'd1);
        press(K_NUM, 3, 1, 0);
        repeat (9) do_tick();
        chk("s41_restart", 8'(bus.state), 8'd1);
        chk("s41_money", 8'(bus.money), 8'd3);
        do_tick();
        chk("s41_timeout", 8'(bus.state), 8'd0);
        check_model("s41_end");
`else
        repeat (15) do_tick();
        chk("s34_persist", 8'(bus.state), 8'd1);
        check_model("s34_end");
`endif

        // Reset mid-charge, key held across release.
        if (m_state == 0) press(K_ST, 0, 1, 0);
        press(K_CLR, 0, 1, 0);
        press(K_NUM, 6, 1, 0);
        press(K_CFM, 0, 1, 0);
        chk("s40_remain12", 8'(bus.remain), 8'd12);
        repeat (3) do_tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.start = 1'b1;
        #1;
        model_reset();
        check_model("s40_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("s32_held_start", 8'(bus.state), 8'd0);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        press(K_ST, 0, 50, 0);
        check_model("s40_hold50");

        // Random events against the model.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            case (m_state)
                0: begin
                    k = (r < 7) ? K_ST : 4'($urandom_range(1, 15));
                    press(k, $urandom_range(0, 9), $urandom_range(1, 4), 0);
                end
                1: begin
                    if (r < 2) do_tick();
                    else begin
                        k = (r < 7) ? K_NUM : 4'($urandom_range(1, 15));
                        press(k, (r == 6) ? $urandom_range(0, 15) : $urandom_range(0, 9),
                              $urandom_range(1, 4), 0);
                    end
                end
                2: begin
                    if (r == 0) press(4'($urandom_range(1, 15)), $urandom_range(0, 9), 1, 1);
                    else do_tick();
                end
                default: begin
                    if (r < 3) press(K_ST, 0, $urandom_range(1, 3), 0);
                    else do_tick();
                end
            endcase
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
